fnv_1a_32_stream_checker: RTL and testbench

- Consumer-side counterpart to the team's FNV-1a 32 hasher.
- Accepts a framed byte stream over a valid/ready handshake and applies FNV-1a strictly per octet.
- At end of frame, presents the 32-bit digest plus a match flag against an expected digest supplied by the caller.
- Sits between the I2C target byte interface and the register/readout logic; used to verify payload integrity of received frames.

---
 rtl/fnv_1a_32_stream_checker.sv | 109 ++++++++++
 tb/tb_fnv_1a_32_stream_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnv_1a_32_stream_checker.sv
// Purpose : FNV-1a 32 checker over a framed byte stream; compares the frame digest to a caller-supplied value.
// Latency : one octet per 2 cycles; the s_last octet accepted in cycle N gives m_valid in cycle N+2.
// Backpres: s_ready low during MIX, RESULT and clear; the result is held stable while m_valid && !m_ready.
//
// Ports:
//   clk, reset (async, active-high), clear (sync frame abort)
//   s_data/s_valid/s_last/s_ready : octet input stream
//   exp_digest                    : expected digest, sampled with the s_last octet
//   m_digest/m_match/m_valid/m_ready : frame result
//   busy                          : high while a frame or result is outstanding
module fnv_1a_32_stream_checker #(
    parameter logic [31:0] OFFSET_BASIS = 32'h811C9DC5,
    parameter logic [31:0] FNV_PRIME    = 32'h01000193
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    input  logic [31:0] exp_digest,
    output logic [31:0] m_digest,
    output logic        m_match,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        MIX    = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] hash_q;
    logic [31:0] x_q;
    logic [31:0] exp_q;
    logic        last_q;
    logic [31:0] m_digest_q;
    logic        m_match_q;
    logic        m_valid_q;
    logic [31:0] hash_d;

    // Constant multiply; the 32-bit context truncates the product modulo 2^32.
    assign hash_d = x_q * FNV_PRIME;

    // clear blocks acceptance in the same cycle so an aborted octet is never consumed.
    assign s_ready  = ((state_q == IDLE) || (state_q == ACCEPT)) && !clear;
    assign busy     = (state_q != IDLE);
    assign m_digest = m_digest_q;
    assign m_match  = m_match_q;
    assign m_valid  = m_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hash_q     <= OFFSET_BASIS;
            x_q        <= 32'd0;
            exp_q      <= 32'd0;
            last_q     <= 1'b0;
            m_digest_q <= 32'd0;
            m_match_q  <= 1'b0;
            m_valid_q  <= 1'b0;
        end else if (clear) begin
            state_q   <= IDLE;
            hash_q    <= OFFSET_BASIS;
            m_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCEPT: begin
                    if (s_valid) begin
                        x_q    <= hash_q ^ {24'd0, s_data};
                        last_q <= s_last;
                        if (s_last) begin
                            exp_q <= exp_digest;
                        end
                        state_q <= MIX;
                    end
                end
                MIX: begin
                    hash_q <= hash_d;
                    if (last_q) begin
                        // Result registered directly from the product so it appears in N+2.
                        m_digest_q <= hash_d;
                        m_match_q  <= (hash_d == exp_q);
                        m_valid_q  <= 1'b1;
                        state_q    <= RESULT;
                    end else begin
                        state_q <= ACCEPT;
                    end
                end
                RESULT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        hash_q    <= OFFSET_BASIS;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fnv_1a_32_stream_checker.sv
module tb_fnv_1a_32_stream_checker;

    typedef logic [7:0] u8_t;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] exp_digest;
    logic [31:0] m_digest;
    logic        m_match;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    int vectors;
    int miscompares;

    fnv_1a_32_stream_checker dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .exp_digest (exp_digest),
        .m_digest   (m_digest),
        .m_match    (m_match),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: FNV-1a over the whole octet list with plain 32-bit arithmetic.
    function automatic logic [31:0] fnv_ref(input u8_t q[$]);
        logic [31:0] h;
        h = 32'h811C9DC5;
        foreach (q[i]) begin
            h = (h ^ {24'd0, q[i]}) * 32'h01000193;
        end
        return h;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a frame with s_valid held high; optionally checks pacing and result latency.
    task automatic send_frame(input u8_t q[$], input logic [31:0] e, input bit last_en, input bit chk_timing);
        int edge_no;
        int first_edge;
        int n;
        edge_no    = 0;
        first_edge = 0;
        for (int i = 0; i < q.size(); i++) begin
            s_valid    = 1'b1;
            s_data     = q[i];
            s_last     = last_en && (i == q.size() - 1);
            exp_digest = s_last ? e : $urandom;
            n = 0;
            while (!s_ready && n < 32) begin
                @(posedge clk); #1;
                n++;
                edge_no++;
            end
            check("send_ready_timeout", (n < 32), 1);
            @(posedge clk); #1;
            edge_no++;
            if (i == 0) first_edge = edge_no;
        end
        s_valid    = 1'b0;
        s_last     = 1'b0;
        s_data     = 8'($urandom);
        exp_digest = $urandom;
        if (chk_timing) begin
            check("octet_pacing", edge_no - first_edge, 2 * (q.size() - 1));
            check("mix_valid_low", m_valid, 0);
            check("mix_ready_low", s_ready, 0);
            @(posedge clk); #1;
            check("latency_n2", m_valid, 1);
        end
    endtask

    task automatic get_result(input logic [31:0] dig, input bit match, input int hold);
        int n;
        n = 0;
        while (!m_valid && n < 32) begin
            @(posedge clk); #1;
            n++;
        end
        check("result_timeout", (n < 32), 1);
        check("digest", m_digest, dig);
        check("match", m_match, match);
        check("result_s_ready", s_ready, 0);
        check("result_busy", busy, 1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", m_valid, 1);
            check("hold_digest", m_digest, dig);
            check("hold_match", m_match, match);
            check("hold_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("handoff_valid", m_valid, 0);
        check("handoff_busy", busy, 0);
        check("handoff_s_ready", s_ready, 1);
        check("handoff_digest_held", m_digest, dig);
        check("handoff_match_held", m_match, match);
    endtask

    initial begin
        u8_t         q[$];
        logic [31:0] ref_d;
        logic [31:0] e;
        vectors     = 0;
        miscompares = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        s_data     = 8'd0;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        exp_digest = 32'd0;
        m_ready    = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_digest", m_digest, 0);
        check("rst_m_match", m_match, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Single octet "a"
        q = '{8'h61};
        send_frame(q, 32'hE40C292C, 1, 1);
        get_result(32'hE40C292C, 1, 0);

        // "foobar", matching and mismatching expected digest
        q = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
        send_frame(q, 32'hBF9CF968, 1, 1);
        get_result(32'hBF9CF968, 1, 0);
        send_frame(q, 32'h00000000, 1, 1);
        get_result(32'hBF9CF968, 0, 0);

        // Back-pressure for 5 cycles, then a fresh frame proves reinitialisation
        send_frame(q, 32'hBF9CF968, 1, 0);
        get_result(32'hBF9CF968, 1, 5);
        q = '{8'h61};
        send_frame(q, 32'hE40C292C, 1, 1);
        get_result(32'hE40C292C, 1, 0);

        // Abort "foo" with clear while an octet is offered
        q = '{8'h66, 8'h6F, 8'h6F};
        send_frame(q, 32'd0, 0, 0);
        @(posedge clk); #1;
        check("abort_busy_before", busy, 1);
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h62;
        s_last  = 1'b1;
        #1;
        check("clear_s_ready", s_ready, 0);
        @(posedge clk); #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_m_valid", m_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        check("clear_not_consumed", m_valid, 0);
        q = '{8'h61};
        send_frame(q, 32'hE40C292C, 1, 1);
        get_result(32'hE40C292C, 1, 0);

        // Async reset during MIX of a final octet
        send_frame(q, 32'hE40C292C, 1, 0);
        #1 reset = 1'b1;
        #1;
        check("areset_m_valid", m_valid, 0);
        check("areset_s_ready", s_ready, 1);
        check("areset_busy", busy, 0);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("areset_no_result", m_valid, 0);
        send_frame(q, 32'hE40C292C, 1, 1);
        get_result(32'hE40C292C, 1, 0);

        // Randomised frames against the reference model
        for (int f = 0; f < 24; f++) begin
            q.delete();
            for (int b = 0; b < int'($urandom_range(1, 9)); b++) begin
                q.push_back(8'($urandom_range(0, 255)));
            end
            ref_d = fnv_ref(q);
            e     = ($urandom_range(0, 1) == 1) ? ref_d : $urandom;
            send_frame(q, e, 1, (f % 2) == 0);
            get_result(ref_d, (e == ref_d), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
